// File: rtl/mem_wb_stage_if.sv
// Bundles the ALU-stage inputs and the register-file write-back outputs of mem_wb_stage.
// master drives the instruction side; slave is the stage itself.
interface mem_wb_stage_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              stall;
  logic [15:0]       alu_result;
  logic [15:0]       store_data;
  logic [2:0]        dest_reg;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              push;
  logic              pop;
  logic [15:0]       wb_data;
  logic [2:0]        wb_dest;
  logic              wb_en;
  logic [ADDR_W-1:0] sp_out;
  logic              stack_err;

  modport master (
    output in_valid, stall, alu_result, store_data, dest_reg,
           reg_write, mem_read, mem_write, push, pop,
    input  wb_data, wb_dest, wb_en, sp_out, stack_err
  );

  modport slave (
    input  in_valid, stall, alu_result, store_data, dest_reg,
           reg_write, mem_read, mem_write, push, pop,
    output wb_data, wb_dest, wb_en, sp_out, stack_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: data memory load/store, stack push/pop, registered write-back.
// Latency one cycle; stall freezes all state. Optional MEM_STACK_GUARD_EN blocks SP wrap and flags stack_err.
module mem_wb_stage #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);

  localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(DEPTH - 1);

  logic [15:0]       mem [DEPTH];

  logic [15:0]       wb_data_q, wb_data_d;
  logic [2:0]        wb_dest_q, wb_dest_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              stack_err_q, stack_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] sp_inc;

  assign addr   = bus.alu_result[ADDR_W-1:0];
  assign sp_inc = sp_q + 1'b1;

  always_comb begin
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    wb_en_d     = wb_en_q;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    mem_we      = 1'b0;
    mem_waddr   = addr;

    if (!bus.stall) begin
      wb_en_d = 1'b0;
      if (bus.in_valid) begin
        if (bus.push) begin
`ifdef MEM_STACK_GUARD_EN
          if (sp_q == '0) begin
            stack_err_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = sp_q;
            sp_d      = sp_q - 1'b1;
          end
`else
          mem_we    = 1'b1;
          mem_waddr = sp_q;
          sp_d      = sp_q - 1'b1;
`endif
        end else if (bus.pop) begin
`ifdef MEM_STACK_GUARD_EN
          if (sp_q == SP_TOP) begin
            stack_err_d = 1'b1;
          end else begin
            wb_data_d = mem[sp_inc];
            wb_dest_d = bus.dest_reg;
            wb_en_d   = bus.reg_write;
            sp_d      = sp_inc;
          end
`else
          // Reads the location above the pre-update SP, so a push/pop pair round-trips.
          wb_data_d = mem[sp_inc];
          wb_dest_d = bus.dest_reg;
          wb_en_d   = bus.reg_write;
          sp_d      = sp_inc;
`endif
        end else if (bus.mem_write) begin
          mem_we = 1'b1;
        end else if (bus.mem_read) begin
          wb_data_d = mem[addr];
          wb_dest_d = bus.dest_reg;
          wb_en_d   = bus.reg_write;
        end else begin
          wb_data_d = bus.alu_result;
          wb_dest_d = bus.dest_reg;
          wb_en_d   = bus.reg_write;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      wb_en_q     <= 1'b0;
      sp_q        <= SP_TOP;
      stack_err_q <= 1'b0;
    end else begin
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      wb_en_q     <= wb_en_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Storage is not reset; a write is dropped while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= bus.store_data;
    end
  end

  assign bus.wb_data   = wb_data_q;
  assign bus.wb_dest   = wb_dest_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.sp_out    = sp_q;
  assign bus.stack_err = stack_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: driver queues hand-computed results, a monitor checks them.
module tb_mem_wb_stage;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [2:0]  dest;
    logic        en;
    logic [7:0]  sp;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  mem_wb_stage_if #(.ADDR_W(8)) bus ();

  mem_wb_stage #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("wb_data", bus.wb_data, e.data);
      chk("wb_dest", 16'(bus.wb_dest), 16'(e.dest));
      chk("wb_en", 16'(bus.wb_en), 16'(e.en));
      chk("sp_out", 16'(bus.sp_out), 16'(e.sp));
      chk("stack_err", 16'(bus.stack_err), 16'(e.err));
    end
  end

  // op: 0 pass, 1 mem_read, 2 mem_write, 3 push, 4 pop, 5 push+mem_write
  task automatic step(input logic vld, input logic stl, input int op,
                      input logic [15:0] alu, input logic [15:0] sd,
                      input logic [2:0] dst, input logic rw,
                      input logic [15:0] e_data, input logic [2:0] e_dest,
                      input logic e_en, input logic [7:0] e_sp, input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid   = vld;
    bus.stall      = stl;
    bus.alu_result = alu;
    bus.store_data = sd;
    bus.dest_reg   = dst;
    bus.reg_write  = rw;
    bus.mem_read   = (op == 1);
    bus.mem_write  = (op == 2) || (op == 5);
    bus.push       = (op == 3) || (op == 5);
    bus.pop        = (op == 4);
    e.due  = cyc + 1;
    e.data = e_data;
    e.dest = e_dest;
    e.en   = e_en;
    e.sp   = e_sp;
    e.err  = e_err;
    sb.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.in_valid = 0; bus.stall = 0; bus.alu_result = 0; bus.store_data = 0;
    bus.dest_reg = 0; bus.reg_write = 0; bus.mem_read = 0; bus.mem_write = 0;
    bus.push = 0; bus.pop = 0;
    #12;
    chk("reset wb_data", bus.wb_data, 16'h0000);
    chk("reset wb_en", 16'(bus.wb_en), 16'h0);
    chk("reset sp_out", 16'(bus.sp_out), 16'd255);
    chk("reset stack_err", 16'(bus.stack_err), 16'h0);
    rst_n = 1'b1;

    //   vld stl op alu       sd        dst rw   data      dst en sp   err
    step(1, 0, 0, 16'h1234, 16'h0000, 5, 1, 16'h1234, 5, 1, 255, 0);
    step(1, 0, 2, 16'h0010, 16'hBEEF, 2, 1, 16'h1234, 5, 0, 255, 0);
    step(1, 0, 1, 16'hFF10, 16'h0000, 3, 1, 16'hBEEF, 3, 1, 255, 0);
    step(1, 0, 2, 16'h0020, 16'h1111, 0, 0, 16'hBEEF, 3, 0, 255, 0);
    step(1, 0, 2, 16'h0100, 16'h0F0F, 0, 0, 16'hBEEF, 3, 0, 255, 0);
    step(1, 0, 3, 16'h0000, 16'h00AA, 4, 1, 16'hBEEF, 3, 0, 254, 0);
    step(1, 0, 3, 16'h0000, 16'h00BB, 4, 1, 16'hBEEF, 3, 0, 253, 0);
    step(1, 0, 4, 16'h0000, 16'h0000, 6, 1, 16'h00BB, 6, 1, 254, 0);
    step(1, 0, 4, 16'h0000, 16'h0000, 7, 1, 16'h00AA, 7, 1, 255, 0);
    // push wins over mem_write: mem[0x20] keeps 0x1111, mem[255] takes 0x00CC
    step(1, 0, 5, 16'h0020, 16'h00CC, 0, 0, 16'h00AA, 7, 0, 254, 0);
    step(1, 0, 1, 16'h0020, 16'h0000, 1, 1, 16'h1111, 1, 1, 254, 0);
    step(1, 0, 1, 16'h00FF, 16'h0000, 2, 1, 16'h00CC, 2, 1, 254, 0);
    for (int i = 0; i < 3; i++)
      step(1, 1, 2, 16'h0020, 16'hDEAD, 5, 1, 16'h00CC, 2, 1, 254, 0);
    step(1, 0, 1, 16'h0020, 16'h0000, 4, 1, 16'h1111, 4, 1, 254, 0);
    step(0, 0, 0, 16'h5555, 16'h0000, 6, 1, 16'h1111, 4, 0, 254, 0);
    step(1, 0, 4, 16'h0000, 16'h0000, 0, 1, 16'h00CC, 0, 1, 255, 0);
`ifdef MEM_STACK_GUARD_EN
    step(1, 0, 4, 16'h0000, 16'h0000, 0, 1, 16'h00CC, 0, 0, 255, 1);
    step(1, 0, 0, 16'h0042, 16'h0000, 3, 1, 16'h0042, 3, 1, 255, 1);
`else
    step(1, 0, 4, 16'h0000, 16'h0000, 0, 1, 16'h0F0F, 0, 1, 0, 0);
    step(1, 0, 0, 16'h0042, 16'h0000, 3, 1, 16'h0042, 3, 1, 0, 0);
`endif
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0042, 3, 0,
`ifdef MEM_STACK_GUARD_EN
         255, 1);
`else
         0, 0);
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected results never checked, required 0", sb.size());
    end

    // Mid-cycle reset with a live result on the outputs.
    step(1, 0, 0, 16'h0077, 16'h0000, 6, 1, 16'h0077, 6, 1,
`ifdef MEM_STACK_GUARD_EN
         255, 1);
`else
         0, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async wb_data", bus.wb_data, 16'h0000);
    chk("async wb_dest", 16'(bus.wb_dest), 16'h0);
    chk("async wb_en", 16'(bus.wb_en), 16'h0);
    chk("async sp_out", 16'(bus.sp_out), 16'd255);
    chk("async stack_err", 16'(bus.stack_err), 16'h0);
    #10;
    rst_n = 1'b1;
    sb.delete();
    // Memory survives reset: 0x20 still holds 0x1111.
    bus.stall = 0;
    step(1, 0, 1, 16'h0020, 16'h0000, 2, 1, 16'h1111, 2, 1, 255, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain2: %0d expected results never checked, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
